// File: rtl/diaosi_types_pkg.sv
// Shared pipeline types: latch state encoding, counter saturation helper and the
// packed stage bundles carried across each pipeline boundary.
package diaosi_types_pkg;

    // EMPTY: no entry; FULL: one entry; SKID: main plus skid entry held.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    // All-ones value for a counter of width w (w limited to 64).
    function automatic logic [63:0] pipe_cnt_max(input int unsigned w);
        logic [63:0] one;
        one = 64'd1;
        if (w >= 64) begin
            return '1;
        end
        return (one << w) - 64'd1;
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_dc_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [3:0]  alu_op;
        logic        wb_en;
    } dc_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        wb_en;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        wb_en;
    } mem_wb_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the latch performance counters; sticks at all-ones.
module pipe_sat_counter
    import diaosi_types_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             en,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(pipe_cnt_max(CNT_W));

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && inc && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register, cleared by asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_latch.sv
// Generic inter-stage pipeline latch with valid/ready handshake, stall enable,
// flush-to-bubble and saturating stall/flush counters.
// Optional feature macro: PIPE_SKID_EN adds a skid register and a registered in_ready.
module pipe_stage_latch
    import diaosi_types_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             xfer_in, xfer_out;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = data_q;
    assign xfer_out  = out_valid & out_ready & en;
    assign xfer_in   = in_valid & in_ready & en & ~flush;

`ifdef PIPE_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;

    // Registered readiness; flush always drains the incoming beat.
    assign in_ready = flush | (en & in_ready_q);
`else
    // Combinational back-pressure: accept when empty or when the held beat leaves.
    assign in_ready = (en & ~flush) ? (~out_valid | out_ready) : flush;
`endif

    // Next-state and payload selection; flush overrides enable and all transfers.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
`ifdef PIPE_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = EMPTY;
            data_d  = FLUSH_VAL;
        end else if (en) begin
            case (state_q)
                EMPTY: begin
                    if (xfer_in) begin
                        state_d = FULL;
                        data_d  = in_data;
                    end
                end
                FULL: begin
                    if (xfer_in && xfer_out) begin
                        data_d = in_data;
                    end else if (xfer_out) begin
                        state_d = EMPTY;
`ifdef PIPE_SKID_EN
                    end else if (xfer_in) begin
                        // Downstream stalled: park the new beat behind the held one.
                        state_d = SKID;
                        skid_d  = in_data;
`endif
                    end
                end
`ifdef PIPE_SKID_EN
                SKID: begin
                    if (xfer_out) begin
                        state_d = FULL;
                        data_d  = skid_q;
                    end
                end
`endif
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
`ifdef PIPE_SKID_EN
        in_ready_d = (state_d != SKID);
`endif
    end

    // State and payload registers; reset loads the bubble encoding.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= EMPTY;
            data_q     <= FLUSH_VAL;
`ifdef PIPE_SKID_EN
            skid_q     <= FLUSH_VAL;
            in_ready_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
`ifdef PIPE_SKID_EN
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
`endif
        end
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (out_valid & ~out_ready),
        .en    (en),
        .clear (1'b0),
        .cnt   (stall_cnt)
    );

    // Flush counts regardless of en since flush has priority over the enable.
    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (flush & out_valid),
        .en    (1'b1),
        .clear (1'b0),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Directed bench for pipe_stage_latch with a data scoreboard; a second instance
// with a 4-bit counter checks saturation.
module tb_pipe_stage_latch;

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST;
    logic        en, flush, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [15:0] stall_cnt, flush_cnt;
    logic        in_ready4, out_valid4;
    logic [31:0] out_data4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb[$];

    always #5 CLK = ~CLK;

    pipe_stage_latch #(
        .WIDTH     (32),
        .FLUSH_VAL (Nop),
        .CNT_W     (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    pipe_stage_latch #(
        .WIDTH     (32),
        .FLUSH_VAL (Nop),
        .CNT_W     (4)
    ) dut4 (
        .CLK       (CLK),
        .RST       (RST),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready4),
        .out_valid (out_valid4),
        .out_data  (out_data4),
        .out_ready (out_ready),
        .stall_cnt (stall_cnt4),
        .flush_cnt (flush_cnt4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: scoreboard the handshakes at the falling edge, then settle past the rise.
    task automatic tick();
        @(negedge CLK);
        if (flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready && en) begin
                if (sb.size() == 0) begin
                    check("sb_underflow_valid", out_valid, 0);
                end else begin
                    check("sb_data", out_data, sb.pop_front());
                end
            end
            if (in_valid && in_ready && en) begin
                sb.push_back(in_data);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST = 1'b1;
        #1;
        sb.delete();
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST       = 1'b1;
        en        = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, Nop);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Reset mid-stream: asynchronous clear before the next edge.
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        tick();
        in_valid = 1'b0;
        check("load_valid", out_valid, 1);
        check("load_data", out_data, 32'hDEAD_BEEF);
        tick();
        check("pre_rst_stall", stall_cnt, 1);
        #2;
        RST = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, Nop);
        check("arst_stall_cnt", stall_cnt, 0);
        sb.delete();
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Streaming 1..8 with no gaps.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 32'(i);
            #1;
            check("stream_in_ready", in_ready, 1);
            tick();
            check("stream_valid", out_valid, 1);
            check("stream_data", out_data, 32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", out_valid, 0);

        // Stall for 5 cycles: payload stable, stall counter tracks.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA5A5_0001;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, 32'hA5A5_0001);
`ifdef PIPE_SKID_EN
            check("stall_in_ready", in_ready, 1);
`else
            check("stall_in_ready", in_ready, 0);
`endif
        end
        check("stall_cnt5", stall_cnt, 5);
        out_ready = 1'b1;
        tick();
        check("stall_release_empty", out_valid, 0);
        check("stall_cnt_hold", stall_cnt, 5);

        // Flush with a held entry and an incoming beat.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_1111;
        tick();
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h0000_2222;
        #1;
        check("flush_in_ready", in_ready, 1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_out_data", out_data, Nop);
        check("flush_cnt1", flush_cnt, 1);
        tick();
        check("flush_no_ghost", out_valid, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_empty_cnt", flush_cnt, 1);
        check("flush_empty_valid", out_valid, 0);
        check("flush_stall_cnt", stall_cnt, 5);

        // Enable low: frozen, no transfers either way.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_3333;
        tick();
        en        = 1'b0;
        in_data   = 32'h0000_4444;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("en0_in_ready", in_ready, 0);
            tick();
            check("en0_valid", out_valid, 1);
            check("en0_data", out_data, 32'h0000_3333);
        end
        en       = 1'b1;
        in_valid = 1'b0;
        tick();
        check("en1_drain", out_valid, 0);
        check("en0_stall_cnt", stall_cnt, 5);

        // Saturation with a 4-bit counter.
        pulse_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_5555;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 10 || i == 15 || i == 20) begin
                check("sat_cnt4", stall_cnt4, (i > 15) ? 15 : i);
            end
        end
        check("sat_cnt16", stall_cnt, 20);
        tick();
        check("sat_hold4", stall_cnt4, 15);
        out_ready = 1'b1;
        tick();
        check("sat_drain", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
